// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the peripheral bus controller and its timer.
// The FSM state encoding is exported so checkers can decode dbg_state_o.
package periph_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int SLOT_LSB  = 12;
    localparam int SLOT_W    = 4;
    localparam int OFFSET_W  = 12;
    localparam int MAX_SLOTS = 16;

    localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

    function automatic logic [MAX_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
        return {{(MAX_SLOTS-1){1'b0}}, 1'b1} << slot;
    endfunction

endpackage

// File: rtl/periph_bus_timer.sv
// Wait-state counter for one bus access: cleared outside ACCESS, counts up
// while enabled and holds once it has reached TIMEOUT.
module periph_bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_ni,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired = (count == CNT_W'(TIMEOUT));

endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral interconnect for the 0x2xxx_xxxx region: decodes one CPU request
// at a time onto N slots, waits for the slot, times out and counts errors.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only in IDLE. On the slot
// side p_sel_o acts as valid and p_ready_i[slot] as ready; the access completes
// on the first edge where both are high. rsp_valid_o is a one-cycle pulse that
// cannot be stalled.
module periph_bus_ctrl
    import periph_bus_pkg::*;
#(
    parameter int         NUM_SLOTS = 8,
    parameter logic [3:0] REGION    = 4'h2,
    parameter int         TIMEOUT   = 255,
    parameter int         ERR_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [31:0]               req_addr_i,
    input  logic                      req_we_i,
    input  logic [31:0]               req_wdata_i,
    input  logic [3:0]                req_wmask_i,
    output logic                      rsp_valid_o,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic [NUM_SLOTS-1:0]      p_sel_o,
    output logic                      p_we_o,
    output logic [OFFSET_W-1:0]       p_addr_o,
    output logic [31:0]               p_wdata_o,
    output logic [3:0]                p_wmask_o,
    input  logic [NUM_SLOTS-1:0]      p_ready_i,
    input  logic [32*NUM_SLOTS-1:0]   p_rdata_i,
    output logic [ERR_CNT_W-1:0]      err_count_o,
    output logic [1:0]                dbg_state_o
);

    localparam int RD_PAD_W = 32 * MAX_SLOTS;

    state_t                 state;
    logic [SLOT_W-1:0]      req_slot;
    logic [SLOT_W-1:0]      slot_q;
    logic                   decode_ok;
    logic [MAX_SLOTS-1:0]   req_onehot;
    logic [MAX_SLOTS-1:0]   ready_pad;
    logic [RD_PAD_W-1:0]    rdata_pad;
    logic                   slot_ready;
    logic [31:0]            slot_rdata;
    logic                   expired;
    logic                   unused_addr_bits;

    assign req_slot   = req_addr_i[SLOT_LSB +: SLOT_W];
    assign decode_ok  = (req_addr_i[31:28] == REGION) &&
                        ({28'd0, req_slot} < 32'(NUM_SLOTS));
    assign req_onehot = slot_onehot(req_slot);

    // Widen the slot buses to 16 lanes so a 4-bit slot index never overruns them.
    assign ready_pad  = MAX_SLOTS'(p_ready_i);
    assign rdata_pad  = RD_PAD_W'(p_rdata_i);
    assign slot_ready = ready_pad[slot_q];
    assign slot_rdata = rdata_pad[{slot_q, 5'd0} +: 32];

    assign unused_addr_bits = ^req_addr_i[27:16];
    assign dbg_state_o      = state;

    periph_bus_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset_ni (reset_ni),
        .clr      (state != ACCESS),
        .en       (state == ACCESS),
        .expired  (expired)
    );

    always_ff @(posedge clk or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= IDLE;
            slot_q      <= '0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= ERR_RDATA;
            p_sel_o     <= '0;
            p_we_o      <= 1'b0;
            p_addr_o    <= '0;
            p_wdata_o   <= '0;
            p_wmask_o   <= '0;
            err_count_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= ERR_RDATA;

            case (state)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_ready_o <= 1'b0;
                        if (decode_ok) begin
                            state     <= ACCESS;
                            slot_q    <= req_slot;
                            p_sel_o   <= req_onehot[NUM_SLOTS-1:0];
                            p_we_o    <= req_we_i;
                            p_addr_o  <= req_addr_i[OFFSET_W-1:0];
                            p_wdata_o <= req_wdata_i;
                            p_wmask_o <= req_we_i ? req_wmask_i : 4'h0;
                        end else begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            if (err_count_o != '1)
                                err_count_o <= err_count_o + ERR_CNT_W'(1);
                        end
                    end
                end

                ACCESS: begin
                    // Ready is checked before the timeout so a late slot still succeeds.
                    if (slot_ready) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= p_we_o ? ERR_RDATA : slot_rdata;
                        p_sel_o     <= '0;
                        p_we_o      <= 1'b0;
                        p_wmask_o   <= 4'h0;
                    end else if (expired) begin
                        state       <= RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        p_sel_o     <= '0;
                        p_we_o      <= 1'b0;
                        p_wmask_o   <= 4'h0;
                        if (err_count_o != '1)
                            err_count_o <= err_count_o + ERR_CNT_W'(1);
                    end
                end

                RESP: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                end

                default: begin
                    state       <= IDLE;
                    req_ready_o <= 1'b1;
                    p_sel_o     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Self-checking bench for periph_bus_ctrl with an 8-slot, TIMEOUT=4, 3-bit
// error counter configuration; expectations come from a transaction-level model.
module tb_periph_bus_ctrl;
    import periph_bus_pkg::*;

    localparam int NS = 8;
    localparam int TO = 4;
    localparam int CW = 3;

    logic              clk = 1'b0;
    logic              reset_ni;
    logic              req_valid_i;
    logic              req_ready_o;
    logic [31:0]       req_addr_i;
    logic              req_we_i;
    logic [31:0]       req_wdata_i;
    logic [3:0]        req_wmask_i;
    logic              rsp_valid_o;
    logic [31:0]       rsp_rdata_o;
    logic              rsp_err_o;
    logic [NS-1:0]     p_sel_o;
    logic              p_we_o;
    logic [11:0]       p_addr_o;
    logic [31:0]       p_wdata_o;
    logic [3:0]        p_wmask_o;
    logic [NS-1:0]     p_ready_i;
    logic [32*NS-1:0]  p_rdata_i;
    logic [CW-1:0]     err_count_o;
    logic [1:0]        dbg_state_o;

    int n_checks = 0;
    int n_fail   = 0;
    int model_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rdata;
        int          sel_cycles;
        logic [NS-1:0] sel_seen;
        logic        we_seen;
        logic [11:0] addr_seen;
        logic [31:0] wdata_seen;
        logic [3:0]  wmask_seen;
        logic        stable;
        logic        ready_before;
        logic        ready_after;
        logic        valid_after;
        logic [CW-1:0] cnt_after;
        time         t_accept;
    } obs_t;

    periph_bus_ctrl #(
        .NUM_SLOTS (NS),
        .REGION    (4'h2),
        .TIMEOUT   (TO),
        .ERR_CNT_W (CW)
    ) dut (
        .clk         (clk),
        .reset_ni    (reset_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .req_wmask_i (req_wmask_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .p_sel_o     (p_sel_o),
        .p_we_o      (p_we_o),
        .p_addr_o    (p_addr_o),
        .p_wdata_o   (p_wdata_o),
        .p_wmask_o   (p_wmask_o),
        .p_ready_i   (p_ready_i),
        .p_rdata_i   (p_rdata_i),
        .err_count_o (err_count_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finished");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // A transaction either hits a valid slot (latency 2 + waits, capped by the
    // timeout) or is rejected at decode in one cycle.
    function automatic void ref_model(input logic [31:0] addr, input logic we, input int wait_cyc,
                                      input logic [31:0] rd, output int lat, output logic err,
                                      output logic [31:0] rdata, output int sel_cyc);
        if (addr[31:28] != 4'h2 || int'(addr[15:12]) >= NS) begin
            lat = 1; err = 1'b1; rdata = 32'h0; sel_cyc = 0;
        end else if (wait_cyc <= TO) begin
            lat = 2 + wait_cyc; err = 1'b0; rdata = we ? 32'h0 : rd; sel_cyc = wait_cyc + 1;
        end else begin
            lat = 2 + TO; err = 1'b1; rdata = 32'h0; sel_cyc = TO + 1;
        end
    endfunction

    function automatic int sat_inc(input int cnt, input logic err);
        if (err && cnt < (1 << CW) - 1) return cnt + 1;
        return cnt;
    endfunction

    // ---------------- driver ----------------
    // Called at a falling edge with the DUT idle; returns one falling edge
    // after the response so the next call can be accepted back-to-back.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input logic [3:0] wmask, input int wait_cyc, input logic [31:0] rd,
                           output obs_t o);
        int slot;
        slot = int'(addr[15:12]);
        o.lat = -1; o.err = 1'b0; o.rdata = '0; o.sel_cycles = 0; o.sel_seen = '0;
        o.we_seen = 1'b0; o.addr_seen = '0; o.wdata_seen = '0; o.wmask_seen = '0;
        o.stable = 1'b1; o.ready_after = 1'b0; o.valid_after = 1'b0; o.cnt_after = '0;
        o.ready_before = req_ready_o;
        req_valid_i = 1'b1; req_addr_i = addr; req_we_i = we;
        req_wdata_i = wdata; req_wmask_i = wmask;
        @(posedge clk);
        o.t_accept = $time;
        #1;
        req_valid_i = 1'b0;
        req_addr_i  = $urandom;
        req_we_i    = 1'($urandom_range(0, 1));
        req_wdata_i = $urandom;
        req_wmask_i = 4'($urandom);
        for (int n = 1; n <= 40 && o.lat < 0; n++) begin
            @(negedge clk);
            if (p_sel_o != '0) begin
                if (o.sel_cycles == 0) begin
                    o.we_seen = p_we_o; o.addr_seen = p_addr_o;
                    o.wdata_seen = p_wdata_o; o.wmask_seen = p_wmask_o;
                end else if (p_we_o !== o.we_seen || p_addr_o !== o.addr_seen ||
                             p_wdata_o !== o.wdata_seen || p_wmask_o !== o.wmask_seen) begin
                    o.stable = 1'b0;
                end
                o.sel_cycles++;
                o.sel_seen |= p_sel_o;
            end
            if (rsp_valid_o === 1'b1) begin
                o.lat = n; o.err = rsp_err_o; o.rdata = rsp_rdata_o;
            end
            p_ready_i = NS'($urandom);
            for (int k = 0; k < NS; k++) p_rdata_i[k*32 +: 32] = $urandom;
            if (slot < NS) begin
                p_ready_i[slot] = (n - 1 == wait_cyc);
                p_rdata_i[slot*32 +: 32] = rd;
            end
        end
        @(negedge clk);
        o.valid_after = rsp_valid_o;
        o.ready_after = req_ready_o;
        o.cnt_after   = err_count_o;
        p_ready_i = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_ni = 1'b0; req_valid_i = 1'b0; req_addr_i = '0; req_we_i = 1'b0;
        req_wdata_i = '0; req_wmask_i = '0; p_ready_i = '0; p_rdata_i = '0;
        #12;
        n_checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o} !== 3'b100) begin
            n_fail++; $display("FAIL reset_hs: got rdy/vld/err=%b required 100", {req_ready_o, rsp_valid_o, rsp_err_o});
        end
        n_checks++;
        if ({p_sel_o, p_we_o, p_wmask_o, p_addr_o} !== '0 || p_wdata_o !== 32'h0 || rsp_rdata_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: got sel=%h we=%b addr=%h wdata=%h rdata=%h required all 0",
                               p_sel_o, p_we_o, p_addr_o, p_wdata_o, rsp_rdata_o);
        end
        n_checks++;
        if (err_count_o !== '0 || dbg_state_o !== IDLE) begin
            n_fail++; $display("FAIL reset_state: got cnt=%0d state=%0d required 0/%0d", err_count_o, dbg_state_o, IDLE);
        end
        @(negedge clk);
        reset_ni = 1'b1;
        model_cnt = 0;
        @(negedge clk);
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        run_txn(32'h2000_1000, 1'b1, 32'h0000_00A5, 4'hF, 0, 32'hDEAD_BEEF, o);
        n_checks++;
        if (o.lat !== 2 || o.err !== 1'b0 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL wr_rsp: got lat=%0d err=%b rdata=%h required 2/0/0", o.lat, o.err, o.rdata);
        end
        n_checks++;
        if (o.sel_cycles !== 1 || o.sel_seen !== 8'b0000_0010) begin
            n_fail++; $display("FAIL wr_sel: got %0d cycles sel=%b required 1 cycle 00000010", o.sel_cycles, o.sel_seen);
        end
        n_checks++;
        if (o.we_seen !== 1'b1 || o.wdata_seen !== 32'hA5 || o.wmask_seen !== 4'hF || o.addr_seen !== 12'h000) begin
            n_fail++; $display("FAIL wr_bus: got we=%b wdata=%h mask=%h addr=%h required 1/a5/f/000",
                               o.we_seen, o.wdata_seen, o.wmask_seen, o.addr_seen);
        end
        n_checks++;
        if (o.ready_before !== 1'b1 || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
            n_fail++; $display("FAIL wr_hs: got rdy_before=%b vld_after=%b rdy_after=%b required 1/0/1",
                               o.ready_before, o.valid_after, o.ready_after);
        end
    endtask

    task automatic test_read_wait();
        obs_t o;
        run_txn(32'h2000_2004, 1'b0, 32'h1234_5678, 4'hF, 3, 32'h0000_0003, o);
        n_checks++;
        if (o.lat !== 5 || o.err !== 1'b0 || o.rdata !== 32'h3) begin
            n_fail++; $display("FAIL rd_rsp: got lat=%0d err=%b rdata=%h required 5/0/3", o.lat, o.err, o.rdata);
        end
        n_checks++;
        if (o.sel_cycles !== 4 || o.sel_seen !== 8'b0000_0100 || o.stable !== 1'b1) begin
            n_fail++; $display("FAIL rd_sel: got %0d cycles sel=%b stable=%b required 4/00000100/1",
                               o.sel_cycles, o.sel_seen, o.stable);
        end
        n_checks++;
        if (o.wmask_seen !== 4'h0 || o.we_seen !== 1'b0 || o.addr_seen !== 12'h004) begin
            n_fail++; $display("FAIL rd_bus: got mask=%h we=%b addr=%h required 0/0/004", o.wmask_seen, o.we_seen, o.addr_seen);
        end
    endtask

    task automatic test_decode_error();
        obs_t o;
        run_txn(32'h2000_A000, 1'b0, 32'h0, 4'h0, 0, 32'hFFFF_FFFF, o);
        model_cnt = sat_inc(model_cnt, 1'b1);
        n_checks++;
        if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || o.sel_cycles !== 0) begin
            n_fail++; $display("FAIL dec_err: got lat=%0d err=%b rdata=%h sel_cycles=%0d required 1/1/0/0",
                               o.lat, o.err, o.rdata, o.sel_cycles);
        end
        n_checks++;
        if (int'(o.cnt_after) !== model_cnt) begin
            n_fail++; $display("FAIL dec_cnt: got %0d required %0d", o.cnt_after, model_cnt);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        run_txn(32'h2000_3008, 1'b0, 32'h0, 4'h0, 1000, 32'h1111_1111, o);
        model_cnt = sat_inc(model_cnt, 1'b1);
        n_checks++;
        if (o.lat !== 2 + TO || o.err !== 1'b1 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL to_rsp: got lat=%0d err=%b rdata=%h required %0d/1/0", o.lat, o.err, o.rdata, 2 + TO);
        end
        n_checks++;
        if (o.sel_cycles !== TO + 1 || o.sel_seen !== 8'b0000_1000 || int'(o.cnt_after) !== model_cnt) begin
            n_fail++; $display("FAIL to_sel: got %0d cycles sel=%b cnt=%0d required %0d/00001000/%0d",
                               o.sel_cycles, o.sel_seen, o.cnt_after, TO + 1, model_cnt);
        end
        run_txn(32'h2000_3008, 1'b0, 32'h0, 4'h0, TO, 32'h55AA_33CC, o);
        n_checks++;
        if (o.lat !== 2 + TO || o.err !== 1'b0 || o.rdata !== 32'h55AA_33CC || int'(o.cnt_after) !== model_cnt) begin
            n_fail++; $display("FAIL to_edge: got lat=%0d err=%b rdata=%h cnt=%0d required %0d/0/55aa33cc/%0d",
                               o.lat, o.err, o.rdata, o.cnt_after, 2 + TO, model_cnt);
        end
    endtask

    task automatic test_saturation();
        obs_t o;
        for (int i = 0; i < 9; i++) begin
            run_txn({4'h1, 28'($urandom)}, 1'b0, 32'h0, 4'h0, 0, 32'h0, o);
            model_cnt = sat_inc(model_cnt, 1'b1);
            n_checks++;
            if (o.lat !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0 || int'(o.cnt_after) !== model_cnt) begin
                n_fail++; $display("FAIL sat_%0d: got lat=%0d err=%b rdata=%h cnt=%0d required 1/1/0/%0d",
                                   i, o.lat, o.err, o.rdata, o.cnt_after, model_cnt);
            end
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] addr, wdata, rd, exp_rdata, exp_word;
        logic [3:0] wmask;
        logic we, exp_err;
        int wait_cyc, exp_lat, exp_sc;
        logic [NS-1:0] exp_sel;
        for (int i = 0; i < 40; i++) begin
            addr  = {($urandom_range(0, 7) == 0) ? 4'h3 : 4'h2, 12'($urandom),
                     4'($urandom_range(0, 11)), 12'($urandom)};
            we    = 1'($urandom_range(0, 1));
            wdata = $urandom; wmask = 4'($urandom); rd = $urandom;
            wait_cyc = $urandom_range(0, 6);
            ref_model(addr, we, wait_cyc, rd, exp_lat, exp_err, exp_rdata, exp_sc);
            exp_sel = '0;
            if (exp_sc > 0) exp_sel[addr[15:12]] = 1'b1;
            model_cnt = sat_inc(model_cnt, exp_err);
            exp_q.push_back(exp_rdata);
            run_txn(addr, we, wdata, wmask, wait_cyc, rd, o);
            exp_word = exp_q.pop_front();
            n_checks++;
            if (o.lat !== exp_lat || o.err !== exp_err || o.rdata !== exp_word) begin
                n_fail++; $display("FAIL rnd_rsp_%0d: got lat=%0d err=%b rdata=%h required %0d/%b/%h",
                                   i, o.lat, o.err, o.rdata, exp_lat, exp_err, exp_word);
            end
            n_checks++;
            if (o.sel_cycles !== exp_sc || o.sel_seen !== exp_sel || o.stable !== 1'b1) begin
                n_fail++; $display("FAIL rnd_sel_%0d: got %0d cycles sel=%b stable=%b required %0d/%b/1",
                                   i, o.sel_cycles, o.sel_seen, o.stable, exp_sc, exp_sel);
            end
            if (exp_sc > 0) begin
                n_checks++;
                if (o.we_seen !== we || o.addr_seen !== addr[11:0] || o.wdata_seen !== wdata ||
                    o.wmask_seen !== (we ? wmask : 4'h0)) begin
                    n_fail++; $display("FAIL rnd_bus_%0d: got we=%b addr=%h wdata=%h mask=%h required %b/%h/%h/%h",
                                       i, o.we_seen, o.addr_seen, o.wdata_seen, o.wmask_seen,
                                       we, addr[11:0], wdata, we ? wmask : 4'h0);
                end
            end
            n_checks++;
            if (int'(o.cnt_after) !== model_cnt || o.valid_after !== 1'b0 || o.ready_after !== 1'b1) begin
                n_fail++; $display("FAIL rnd_tail_%0d: got cnt=%0d vld=%b rdy=%b required %0d/0/1",
                                   i, o.cnt_after, o.valid_after, o.ready_after, model_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        time t_prev;
        int slots[3] = '{0, 1, 7};
        for (int i = 0; i < 3; i++) begin
            run_txn({4'h2, 12'h000, 4'(slots[i]), 12'h010}, 1'b0, 32'h0, 4'h0, 0, 32'hB0 + 32'(i), o);
            n_checks++;
            if (o.lat !== 2 || o.rdata !== 32'hB0 + 32'(i) || o.err !== 1'b0) begin
                n_fail++; $display("FAIL b2b_rsp_%0d: got lat=%0d rdata=%h err=%b required 2/%h/0",
                                   i, o.lat, o.rdata, o.err, 32'hB0 + 32'(i));
            end
            if (i > 0) begin
                n_checks++;
                if ((o.t_accept - t_prev) / 10 !== 3) begin
                    n_fail++; $display("FAIL b2b_gap_%0d: got %0d cycles required 3", i, (o.t_accept - t_prev) / 10);
                end
            end
            t_prev = o.t_accept;
        end
    endtask

    task automatic test_reset_mid_access();
        int seen_valid = 0;
        req_valid_i = 1'b1; req_addr_i = 32'h2000_5010; req_we_i = 1'b1;
        req_wdata_i = 32'hCAFE_F00D; req_wmask_i = 4'hF;
        p_ready_i = '0;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (p_sel_o !== 8'b0010_0000) begin
            n_fail++; $display("FAIL rst_pre_sel: got %b required 00100000", p_sel_o);
        end
        #2 reset_ni = 1'b0;
        #1;
        n_checks++;
        if (p_sel_o !== '0 || p_we_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_async: got sel=%b we=%b vld=%b required 0/0/0", p_sel_o, p_we_o, rsp_valid_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0) seen_valid++;
        end
        reset_ni = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid_o !== 1'b0 || p_sel_o !== '0) seen_valid++;
        end
        n_checks++;
        if (seen_valid !== 0) begin
            n_fail++; $display("FAIL rst_no_rsp: got %0d active cycles required 0", seen_valid);
        end
        n_checks++;
        if (req_ready_o !== 1'b1 || int'(err_count_o) !== model_cnt || dbg_state_o !== IDLE) begin
            n_fail++; $display("FAIL rst_after: got rdy=%b cnt=%0d state=%0d required 1/%0d/%0d",
                               req_ready_o, err_count_o, dbg_state_o, model_cnt, IDLE);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_decode_error();
        test_timeout();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
